// File: rtl/mrma_sync_ctl_if.sv
// Handshake bundle between the router-side client logic, the synchronous front end
// and the asynchronous match arbiter.
interface mrma_sync_ctl_if #(
    parameter int N = 2,
    parameter int M = 2
);
    logic [N-1:0]         creq;
    logic [N-1:0]         ctail;
    logic [N-1:0]         cgnt;
    logic [N-1:0][M-1:0]  csel;
    logic [M-1:0]         rfree;
    logic                 err;
    logic [N-1:0]         c;
    logic [N-1:0]         ca;
    logic [M-1:0]         r;
    logic [M-1:0]         ra;
    logic [M-1:0][N-1:0]  cfg;

    // master: clients plus arbiter side; slave: the front end itself
    modport master (
        output creq, ctail, rfree, ca, ra, cfg,
        input  cgnt, csel, err, c, r
    );
    modport slave (
        input  creq, ctail, rfree, ca, ra, cfg,
        output cgnt, csel, err, c, r
    );
endinterface

// File: rtl/mrma_sync_ctl.sv
// Synchronous front end for the multi-resource match arbiter: 4-phase c/r requests
// out, synchronized acks in, registered one-hot grants held until the client tail.
//
// client state | meaning
// IDLE         | no request outstanding, c=0
// REQ          | c=1, waiting for synchronized ca to capture the cfg column
// HOLD         | c=1, grant and csel registered until ctail
// REL          | c=0, waiting for synchronized ca to return to zero
//
// resource state | meaning
// OFF            | r=0, resource not offered
// ON             | r=1, resource offered to the arbiter
module mrma_sync_ctl #(
    parameter int N    = 2,
    parameter int M    = 2,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mrma_sync_ctl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, REL} cst_t;
    typedef enum logic       {OFF, ON}              rs_t;

    cst_t                 cst [N];
    rs_t                  rs  [M];
    logic [N-1:0]         ca_sync [SYNC];
    logic [M-1:0]         ra_sync [SYNC];
    logic [N-1:0]         ca_s;
    logic [M-1:0]         ra_s;
    logic [N-1:0][M-1:0]  cfg_col;
    logic                 any_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC; k++) begin
                ca_sync[k] <= '0;
                ra_sync[k] <= '0;
            end
        end else begin
            ca_sync[0] <= bus.ca;
            ra_sync[0] <= bus.ra;
            for (int k = 1; k < SYNC; k++) begin
                ca_sync[k] <= ca_sync[k-1];
                ra_sync[k] <= ra_sync[k-1];
            end
        end
    end

    assign ca_s = ca_sync[SYNC-1];
    assign ra_s = ra_sync[SYNC-1];

    // cfg is row-per-resource; each client captures its own column
    always_comb begin
        cfg_col = '0;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < M; i++)
                cfg_col[j][i] = bus.cfg[i][j];
    end

    always_comb begin
        any_req = 1'b0;
        for (int j = 0; j < N; j++)
            if (cst[j] == REQ) any_req = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N; j++) cst[j] <= IDLE;
            for (int i = 0; i < M; i++) rs[i] <= OFF;
            bus.c    <= '0;
            bus.cgnt <= '0;
            bus.csel <= '0;
            bus.r    <= '0;
            bus.err  <= 1'b0;
        end else begin
            for (int j = 0; j < N; j++) begin
                case (cst[j])
                    IDLE: if (bus.creq[j]) begin
                        cst[j]   <= REQ;
                        bus.c[j] <= 1'b1;
                    end
                    // cfg is held stable by the arbiter while c[j] is high
                    REQ: if (ca_s[j]) begin
                        cst[j]      <= HOLD;
                        bus.cgnt[j] <= 1'b1;
                        bus.csel[j] <= cfg_col[j];
                        if (!$onehot(cfg_col[j])) bus.err <= 1'b1;
                    end
                    HOLD: if (bus.ctail[j]) begin
                        cst[j]      <= REL;
                        bus.c[j]    <= 1'b0;
                        bus.cgnt[j] <= 1'b0;
                        bus.csel[j] <= '0;
                    end
                    REL: if (!ca_s[j]) cst[j] <= IDLE;
                    default: cst[j] <= IDLE;
                endcase
            end
            // an offer is never withdrawn while some client could still be matched to it
            for (int i = 0; i < M; i++) begin
                case (rs[i])
                    OFF: if (bus.rfree[i]) begin
                        rs[i]    <= ON;
                        bus.r[i] <= 1'b1;
                    end
                    ON: if (!bus.rfree[i] && !ra_s[i] && !any_req) begin
                        rs[i]    <= OFF;
                        bus.r[i] <= 1'b0;
                    end
                    default: rs[i] <= OFF;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mrma_sync_ctl.sv
// Bench for mrma_sync_ctl: behavioural arbiter model, directed protocol steps, then
// randomized traffic checked against a grant-timing scoreboard.
module tb_mrma_sync_ctl;
    localparam int N    = 2;
    localparam int M    = 2;
    localparam int SYNC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic             arb_on  = 1'b1;
    logic             arb_bad = 1'b0;
    int               owner   [M];
    int               ca_rise [N];
    logic [M-1:0]     sel_rec [N];

    logic [N-1:0]     exp_gnt;
    logic [M-1:0]     exp_sel [N];
    logic [N-1:0]     tdrv;
    logic [N-1:0]     win;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mrma_sync_ctl_if #(.N(N), .M(M)) bus ();

    mrma_sync_ctl #(.N(N), .M(M), .SYNC(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Arbiter model: acks a requesting client with the lowest offered, unowned
    // resource; releases the match once the client drops c.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.ca  = '0;
            bus.ra  = '0;
            bus.cfg = '0;
            for (int i = 0; i < M; i++) owner[i] = -1;
            for (int j = 0; j < N; j++) begin
                ca_rise[j] = -100;
                sel_rec[j] = '0;
            end
        end else if (arb_on) begin
            for (int j = 0; j < N; j++) begin
                if (bus.ca[j] && !bus.c[j]) begin
                    bus.ca[j] = 1'b0;
                    for (int i = 0; i < M; i++) begin
                        bus.cfg[i][j] = 1'b0;
                        if (owner[i] == j) begin
                            owner[i]  = -1;
                            bus.ra[i] = 1'b0;
                        end
                    end
                end
            end
            for (int j = 0; j < N; j++) begin
                for (int i = 0; i < M; i++) begin
                    if (bus.c[j] && !bus.ca[j] && bus.r[i] && owner[i] < 0) begin
                        owner[i]      = j;
                        bus.ra[i]     = 1'b1;
                        bus.ca[j]     = 1'b1;
                        bus.cfg[i][j] = 1'b1;
                        if (arb_bad)
                            for (int k = 0; k < M; k++) bus.cfg[k][j] = 1'b1;
                        ca_rise[j]    = cyc;
                        sel_rec[j]    = '0;
                        sel_rec[j][i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_gnt(input logic [N-1:0] want, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.cgnt !== want && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.cgnt), 32'(want));
    endtask

    task automatic tail(input logic [N-1:0] mask);
        @(negedge clk);
        bus.ctail = mask;
        bus.creq  = bus.creq & ~mask;
        step();
        @(negedge clk);
        bus.ctail = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.creq  = '0;
        bus.ctail = '0;
        bus.rfree = '0;
        exp_gnt   = '0;
        for (int j = 0; j < N; j++) exp_sel[j] = '0;
        #1;
        chk("rst_c", 32'(bus.c), 0);
        chk("rst_r", 32'(bus.r), 0);
        chk("rst_gnt", 32'(bus.cgnt), 0);
        chk("rst_err", 32'(bus.err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        settle(2);

        // single grant with exact latency
        @(negedge clk);
        bus.rfree = 2'b01;
        bus.creq  = 2'b01;
        step();
        chk("sg_c", 32'(bus.c), 32'h1);
        chk("sg_r", 32'(bus.r), 32'h1);
        step();
        chk("sg_gnt_e1", 32'(bus.cgnt), 0);
        step();
        chk("sg_gnt_e2", 32'(bus.cgnt), 0);
        step();
        chk("sg_gnt", 32'(bus.cgnt), 32'h1);
        chk("sg_csel0", 32'(bus.csel[0]), 32'h1);
        chk("sg_csel1", 32'(bus.csel[1]), 0);
        @(negedge clk);
        bus.creq  = 2'b00;
        bus.ctail = 2'b01;
        step();
        chk("sg_tail_gnt", 32'(bus.cgnt), 0);
        chk("sg_tail_c", 32'(bus.c), 0);
        chk("sg_tail_csel", 32'(bus.csel[0]), 0);
        // immediate re-request must wait for the full return to zero
        @(negedge clk);
        bus.ctail = 2'b00;
        bus.creq  = 2'b01;
        step();
        chk("rtz_c1", 32'(bus.c), 0);
        step();
        chk("rtz_c2", 32'(bus.c), 0);
        step();
        chk("rtz_c3", 32'(bus.c), 0);
        step();
        chk("rtz_c4", 32'(bus.c), 32'h1);
        wait_gnt(2'b01, 10, "rtz_regrant");
        tail(2'b01);
        settle(6);

        // contention on a single resource
        @(negedge clk);
        bus.creq = 2'b11;
        for (int n = 0; n < 12 && bus.cgnt == '0; n++) step();
        chk("cont_one", 32'($countones(bus.cgnt)), 1);
        win = bus.cgnt;
        tail(win);
        wait_gnt(~win, 15, "cont_other");
        chk("cont_other_sel", 32'(win[0] ? bus.csel[1] : bus.csel[0]), 32'h1);
        tail(~win);
        settle(6);

        // two-way match
        @(negedge clk);
        bus.rfree = 2'b11;
        bus.creq  = 2'b11;
        wait_gnt(2'b11, 15, "two_gnt");
        chk("two_sel0", 32'(bus.csel[0]), 32'h1);
        chk("two_sel1", 32'(bus.csel[1]), 32'h2);
        chk("two_disj", 32'(bus.csel[0] & bus.csel[1]), 0);
        chk("two_err", 32'(bus.err), 0);
        tail(2'b11);
        settle(6);

        // creq withdrawn while in REQ
        @(negedge clk);
        arb_on   = 1'b0;
        bus.creq = 2'b01;
        settle(3);
        @(negedge clk);
        bus.creq = 2'b00;
        settle(2);
        chk("wd_c", 32'(bus.c), 32'h1);
        @(negedge clk);
        arb_on = 1'b1;
        wait_gnt(2'b01, 10, "wd_gnt");
        tail(2'b01);
        settle(6);

        // rfree dropped while a client is in REQ
        @(negedge clk);
        arb_on   = 1'b0;
        bus.creq = 2'b10;
        settle(3);
        @(negedge clk);
        bus.rfree = 2'b00;
        bus.creq  = 2'b00;
        settle(4);
        chk("rg_hold_r0", 32'(bus.r[0]), 32'h1);
        @(negedge clk);
        arb_on = 1'b1;
        wait_gnt(2'b10, 10, "rg_gnt");
        @(negedge clk);
        bus.ctail = 2'b10;
        step();
        chk("rg_ra_hold", 32'(bus.r[0]), 32'h1);
        @(negedge clk);
        bus.ctail = 2'b00;
        settle(6);
        chk("rg_off", 32'(bus.r), 0);

        // malformed cfg column
        @(negedge clk);
        arb_bad   = 1'b1;
        bus.rfree = 2'b11;
        bus.creq  = 2'b01;
        wait_gnt(2'b01, 12, "err_gnt");
        chk("err_set", 32'(bus.err), 32'h1);
        chk("err_csel", 32'(bus.csel[0]), 32'h3);
        tail(2'b01);
        arb_bad = 1'b0;
        settle(6);
        chk("err_sticky", 32'(bus.err), 32'h1);
        @(negedge clk);
        bus.creq = 2'b01;
        wait_gnt(2'b01, 12, "hold_gnt");
        chk("err_sticky2", 32'(bus.err), 32'h1);
        settle(2);

        // reset mid-HOLD, checked between clock edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_c", 32'(bus.c), 0);
        chk("ar_r", 32'(bus.r), 0);
        chk("ar_gnt", 32'(bus.cgnt), 0);
        chk("ar_csel", 32'(bus.csel), 0);
        chk("ar_err", 32'(bus.err), 0);
        @(negedge clk);
        bus.creq  = 2'b00;
        bus.rfree = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        settle(2);
        chk("post_c", 32'(bus.c), 0);
        chk("post_r", 32'(bus.r), 0);
        chk("post_gnt", 32'(bus.cgnt), 0);

        // randomized traffic against the grant-timing scoreboard
        @(negedge clk);
        bus.rfree = 2'b11;
        for (int it = 0; it < 500; it++) begin
            @(negedge clk);
            bus.creq = N'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) bus.rfree = M'($urandom_range(0, 3));
            tdrv = '0;
            for (int j = 0; j < N; j++)
                if (exp_gnt[j] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0))
                    tdrv[j] = 1'b1;
            bus.ctail = tdrv;
            step();
            for (int j = 0; j < N; j++) begin
                if (tdrv[j] && exp_gnt[j]) begin
                    exp_gnt[j] = 1'b0;
                    exp_sel[j] = '0;
                end else if (cyc == ca_rise[j] + SYNC + 1) begin
                    exp_gnt[j] = 1'b1;
                    exp_sel[j] = sel_rec[j];
                end
                chk($sformatf("rnd_gnt%0d", j), 32'(bus.cgnt[j]), 32'(exp_gnt[j]));
                chk($sformatf("rnd_sel%0d", j), 32'(bus.csel[j]), 32'(exp_sel[j]));
            end
            chk("rnd_disj", 32'(bus.csel[0] & bus.csel[1]), 0);
            chk("rnd_err", 32'(bus.err), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mrma_sync_ctl.md
# mrma_sync_ctl

Clocked front end for the multi-resource match arbiter: turns synchronous client requests into 4-phase requests `c` to the arbiter and resource availability into requests `r`. It then captures the arbiter's `cfg` match matrix into registered per-client one-hot grants and holds each grant until the client signals its tail. It sits directly upstream and downstream of the arbiter: it drives the arbiter's `c`/`r` inputs and consumes its `ca`/`ra`/`cfg` outputs. It is the bridge between the synchronous router-input logic and the asynchronous allocator.

## Interface
- N, 2, number of clients
- M, 2, number of resources
- SYNC, 2, synchronizer depth on `ca`/`ra` (≥2)

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset. Shared with the arbiter.
- creq  in  N  client j has a head flit and wants a resource (level)
- ctail  in  N  single-cycle pulse: client j has sent its tail and releases its resource
- cgnt  out  N  client j holds a resource (registered)
- csel  out  N×M  `csel[j]` is the one-hot resource held by client j, all-zero when `cgnt[j]`=0
- rfree  in  M  resource i is enabled/available downstream (level)
- err  out  1  sticky: a captured `cfg` column was not one-hot
- c  out  N  request to arbiter (registered, glitch-free)
- ca  in  N  arbiter client ack (asynchronous)
- r  out  M  resource offer to arbiter (registered)
- ra  in  M  arbiter resource ack (asynchronous)
- cfg  in  M×N  arbiter match matrix. `cfg[i][j]`=1 means resource i is matched to client j.

## Operation
- `ca` and `ra` each pass through SYNC flops reset to 0, giving `ca_s` and `ra_s`. `cfg` is not synchronized; it is sampled only when `ca_s[j]` is seen high, because the arbiter's C-elements hold it stable while `c[j]` is high.
- Per-client FSM, states IDLE / REQ / HOLD / REL. `c[j]`=1 in REQ and HOLD.
  - IDLE: if `creq[j]`, go to REQ.
  - REQ: if `ca_s[j]`, capture column j of `cfg` into `csel[j]`, set `cgnt[j]`, go to HOLD.
    - If the captured column is not one-hot, set `err` and still store the column as-is.
    - Falling `creq` in REQ is ignored: a 4-phase request cannot be withdrawn, so the grant is still delivered.
  - HOLD: on `ctail[j]`, clear `cgnt[j]` and `csel[j]` and go to REL.
  - REL: `c[j]`=0. If `ca_s[j]`=0, go to IDLE.
  - `ctail` is ignored outside HOLD.
- Per-resource FSM, states OFF / ON. `r[i]`=1 in ON.
  - OFF: if `rfree[i]`, go to ON.
  - ON: go to OFF only when all of the following hold: `!rfree[i]`, `ra_s[i]`=0, and no client FSM is in REQ. This prevents withdrawal during a possible match.
  - A resource stays ON across successive matches; the arbiter's `r & ~ra` gating re-arms it after `ra` falls.
- `rbusy` is not an output; downstream observes `csel`.
- The OR of `csel` columns must never have a resource bit in two clients; a bench assertion checks this.

## Timing
- Reset values:
  - all FSMs in IDLE / OFF
  - `c`, `r`, `cgnt`, `csel`, `err`, and all sync flops = 0
- Reset takes effect asynchronously, so `c` and `r` drop immediately. Deassertion is synchronous to `clk` via the FSM registers.
- `creq` sampled at edge k: `c` rises after edge k.
- Request to grant: if `ca` rises between edges k+a and k+a+1, `ca_s` is high after edge k+a+SYNC. `cgnt`/`csel` become valid one edge later. Minimum is SYNC+2 cycles from `creq` with a zero-delay arbiter.
- `ctail` at edge t: `cgnt`/`csel` are cleared and `c` falls after edge t. The client re-enters IDLE SYNC+1 edges after `ca` falls.
- A new request from the same client is accepted only from IDLE: no back-to-back grant without a full return-to-zero.
- Simultaneous events are independent per client and per resource. `ctail` and `creq` in the same cycle in HOLD: the tail wins, and the request is served after REL completes.
- Reset mid-HOLD drops the grant without a tail. Downstream must treat reset as a packet abort.

## Test plan
- Reset: assert `rst_n`=0 mid-HOLD -> `c`, `r`, `cgnt`, `csel`, `err` all 0 combinationally; after release, FSMs are in IDLE/OFF.
- Single grant (N=2, M=2, SYNC=2):
  - Stimulus: `rfree`=01, then `creq`=01.
  - Required: `r`=01 and `c`=01 one cycle later.
  - Arbiter model returns `cfg[0][0]`=1 and `ca[0]`=1. Required: `cgnt`=01 and `csel[0]`=01 three cycles after `ca`.
  - `ctail[0]` pulse -> `cgnt`=00 and `c`=00 next cycle; client returns to IDLE after `ca` falls.
- Contention: `creq`=11 with `rfree`=01 -> exactly one `cgnt` bit set. After its `ctail`, the other client is granted resource 0 with no reset needed.
- Two-way match: `creq`=11 with `rfree`=11 -> both granted, `csel` disjoint (e.g. 01/10), `err`=0.
- Protocol guards:
  - `creq` dropped during REQ -> grant still delivered.
  - `rfree[0]` dropped while client 1 is in REQ -> `r[0]` held until REQ clears and `ra_s[0]`=0.
- Error: model drives a `cfg` column of 11 with `ca` -> `err`=1 and sticky until reset.
